order_scheduler: RTL

//  Game-level order controller feeding the per-slot info_display tiles: owns a queue of up to
//  NUM_ORDERS active orders, spawns orders periodically, counts each order's time down once per

---
 rtl/overcooked_pkg.sv | 18 +
 rtl/order_tick_gen.sv | 26 ++
 rtl/order_scheduler.sv | 164 ++++++++++++++++
 3 files changed

// File: rtl/overcooked_pkg.sv
// Shared types and widths for the order scheduler and its tick generator.
package overcooked_pkg;

  localparam int ORDER_TIME_W = 5;
  localparam int SCORE_W      = 10;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    OVER = 2'd2
  } game_state_t;

  typedef struct packed {
    logic                    valid;
    logic [ORDER_TIME_W-1:0] remaining;
  } order_slot_t;

endpackage

// File: rtl/order_tick_gen.sv
// One-second prescaler: counts while enabled, pulses tick on the wrap cycle.
module order_tick_gen #(
  parameter int TICK_CYCLES = 25_000_000
) (
  input  logic clk,
  input  logic rst,
  input  logic en,
  input  logic clear,
  output logic tick
);

  localparam int CW = $clog2(TICK_CYCLES);

  logic [CW-1:0] cnt;

  assign tick = en && (cnt == CW'(TICK_CYCLES - 1));

  always_ff @(posedge clk) begin
    if (rst || clear) begin
      cnt <= '0;
    end else if (en) begin
      cnt <= tick ? '0 : cnt + CW'(1);
    end
  end

endmodule

// File: rtl/order_scheduler.sv
// Game-level order controller: head-compacted order queue, per-second countdown,
// periodic spawning, serve/expiry retirement, score and round timer.
module order_scheduler
  import overcooked_pkg::*;
#(
  parameter int NUM_ORDERS    = 4,
  parameter int TICK_CYCLES   = 25_000_000,
  parameter int ORDER_TIME    = 20,
  parameter int SPAWN_TICKS   = 8,
  parameter int GAME_SECONDS  = 120,
  parameter int SERVE_POINTS  = 10,
  parameter int EXPIRE_POINTS = 5
) (
  input  logic                           pixel_clk_in,
  input  logic                           rst_in,
  input  logic                           start_in,
  input  logic                           serve_in,
  output logic [NUM_ORDERS-1:0]          orders_out,
  output logic [ORDER_TIME_W*NUM_ORDERS-1:0] order_times_out,
  output logic [SCORE_W-1:0]             score_out,
  output logic [7:0]                     game_time_out,
  output logic                           game_over_out,
  output logic                           served_ok_out,
  output logic                           served_fail_out,
  output logic                           expired_out
);

  localparam int SW = (SPAWN_TICKS > 1) ? $clog2(SPAWN_TICKS) : 1;
  // Two guard bits so a serve on a near-max score cannot wrap before clamping.
  localparam int ACC_W = SCORE_W + 2;
  localparam logic signed [ACC_W-1:0] SCORE_MAX  = ACC_W'((1 << SCORE_W) - 1);
  localparam logic signed [ACC_W-1:0] SERVE_ADD  = ACC_W'(SERVE_POINTS);
  localparam logic signed [ACC_W-1:0] EXPIRE_SUB = ACC_W'(EXPIRE_POINTS);

  function automatic logic [SCORE_W-1:0] sat_score(input logic signed [ACC_W-1:0] v);
    if (v < 0)              return '0;
    else if (v > SCORE_MAX) return SCORE_MAX[SCORE_W-1:0];
    else                    return v[SCORE_W-1:0];
  endfunction

  game_state_t                   state, state_n;
  order_slot_t [NUM_ORDERS-1:0]  q, q_n;
  logic [SCORE_W-1:0]            score, score_n;
  logic [7:0]                    game_time, game_time_n;
  logic [SW-1:0]                 spawn_cnt, spawn_cnt_n;
  logic                          ok_n, fail_n, exp_n;
  logic                          tick, start_go, serve_pop, exp_pop, placed;
  logic signed [ACC_W-1:0]       score_acc;

  assign start_go = (state != RUN) && start_in;

  order_tick_gen #(
    .TICK_CYCLES(TICK_CYCLES)
  ) u_tick (
    .clk  (pixel_clk_in),
    .rst  (rst_in),
    .en   (state == RUN),
    .clear(start_go),
    .tick (tick)
  );

  always_comb begin
    state_n     = state;
    q_n         = q;
    score_n     = score;
    game_time_n = game_time;
    spawn_cnt_n = spawn_cnt;
    ok_n        = 1'b0;
    fail_n      = 1'b0;
    exp_n       = 1'b0;
    serve_pop   = 1'b0;
    exp_pop     = 1'b0;
    placed      = 1'b0;
    score_acc   = signed'({2'b00, score});
    case (state)
      IDLE, OVER: begin
        if (start_in) begin
          state_n      = RUN;
          score_n      = '0;
          game_time_n  = 8'(GAME_SECONDS);
          spawn_cnt_n  = '0;
          q_n          = '0;
          q_n[0].valid     = 1'b1;
          q_n[0].remaining = ORDER_TIME_W'(ORDER_TIME);
        end
      end
      RUN: begin
        serve_pop = serve_in && q[0].valid;
        fail_n    = serve_in && !q[0].valid;
        // A serve this cycle takes the head, so it pre-empts any expiry.
        exp_pop   = tick && !serve_pop && q[0].valid && (q[0].remaining == '0);
        ok_n      = serve_pop;
        exp_n     = exp_pop;
        if (serve_pop || exp_pop) begin
          for (int i = 0; i < NUM_ORDERS - 1; i++) q_n[i] = q[i+1];
          q_n[NUM_ORDERS-1] = '0;
        end
        if (serve_pop) score_acc = score_acc + SERVE_ADD;
        if (exp_pop)   score_acc = score_acc - EXPIRE_SUB;
        score_n = sat_score(score_acc);
        if (tick) begin
          for (int i = 0; i < NUM_ORDERS; i++) begin
            if (q_n[i].valid && (q_n[i].remaining != '0))
              q_n[i].remaining = q_n[i].remaining - ORDER_TIME_W'(1);
          end
          game_time_n = game_time - 8'd1;
          if (spawn_cnt == SW'(SPAWN_TICKS - 1)) begin
            spawn_cnt_n = '0;
            for (int i = 0; i < NUM_ORDERS; i++) begin
              if (!placed && !q_n[i].valid) begin
                q_n[i].valid     = 1'b1;
                q_n[i].remaining = ORDER_TIME_W'(ORDER_TIME);
                placed           = 1'b1;
              end
            end
          end else begin
            spawn_cnt_n = spawn_cnt + SW'(1);
          end
          if (game_time == 8'd1) begin
            state_n = OVER;
            q_n     = '0;
          end
        end
      end
      default: state_n = IDLE;
    endcase
  end

  always_ff @(posedge pixel_clk_in) begin
    if (rst_in) begin
      state           <= IDLE;
      q               <= '0;
      score           <= '0;
      game_time       <= '0;
      spawn_cnt       <= '0;
      served_ok_out   <= 1'b0;
      served_fail_out <= 1'b0;
      expired_out     <= 1'b0;
    end else begin
      state           <= state_n;
      q               <= q_n;
      score           <= score_n;
      game_time       <= game_time_n;
      spawn_cnt       <= spawn_cnt_n;
      served_ok_out   <= ok_n;
      served_fail_out <= fail_n;
      expired_out     <= exp_n;
    end
  end

  always_comb begin
    orders_out      = '0;
    order_times_out = '0;
    for (int i = 0; i < NUM_ORDERS; i++) begin
      orders_out[i]                                 = q[i].valid;
      order_times_out[ORDER_TIME_W*i +: ORDER_TIME_W] = q[i].remaining;
    end
  end

  assign score_out     = score;
  assign game_time_out = game_time;
  assign game_over_out = (state == OVER);

endmodule
